// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - run/config/output bundle for the clock divider controller
// master drives run request and divisor updates; slave returns divided clock and status.
interface clk_div_ctrl_if #(
  parameter int W = 4
);
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] div_cur;
  logic         err;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, clk_out, tick, div_cur, err
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, clk_out, tick, div_cur, err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - integer clock divider with 50% duty, graceful stop and wrap-aligned divisor update
// Odd divisors stretch the high phase by half a cycle with a negedge copy of the high-phase register.
module clk_div_ctrl #(
  parameter int W       = 4,
  parameter int DEF_DIV = 4
) (
  input  logic           clk,
  input  logic           rstn,
  clk_div_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [W-1:0] DEF  = W'(DEF_DIV);
  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] TWO  = W'(2);

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0] r_div, w_div_nxt;
  logic [W-1:0] r_pend, w_pend_nxt;
  logic         r_pend_v, w_pend_v_nxt;
  logic         r_err, w_err_nxt;
  logic         r_pos, w_pos_nxt;
  logic         r_neg;

  logic         w_active;
  logic         w_wrap;
  logic         w_xfer;
  logic         w_legal;

  assign w_active = (r_state != OFF);
  assign w_wrap   = w_active && (r_cnt == (r_div - ONE));
  assign w_xfer   = bus.cfg_valid && !r_pend_v;
  assign w_legal  = (bus.cfg_div >= TWO);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= OFF;
      r_cnt    <= ZERO;
      r_div    <= DEF;
      r_pend   <= ZERO;
      r_pend_v <= 1'b0;
      r_err    <= 1'b0;
      r_pos    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div    <= w_div_nxt;
      r_pend   <= w_pend_nxt;
      r_pend_v <= w_pend_v_nxt;
      r_err    <= w_err_nxt;
      r_pos    <= w_pos_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_div_nxt    = r_div;
    w_pend_nxt   = r_pend;
    w_pend_v_nxt = r_pend_v;
    w_err_nxt    = 1'b0;

    case (r_state)
      OFF: begin
        w_cnt_nxt = ZERO;
        if (bus.en) begin
          w_state_nxt = RUN;
        end
      end
      RUN, STOPPING: begin
        if (w_wrap) begin
          // Period boundary: the only point where divisor, parity and run state may change.
          w_cnt_nxt   = ZERO;
          w_state_nxt = bus.en ? RUN : OFF;
          if (r_pend_v) begin
            w_div_nxt    = r_pend;
            w_pend_v_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
          w_state_nxt = bus.en ? RUN : STOPPING;
        end
      end
      default: begin
        w_state_nxt = OFF;
        w_cnt_nxt   = ZERO;
      end
    endcase

    // A transfer landing on a wrap sees r_pend_v low, so it is held for the next wrap.
    if (w_xfer) begin
      if (!w_legal) begin
        w_err_nxt = 1'b1;
      end else if (r_state == OFF) begin
        w_div_nxt = bus.cfg_div;
      end else begin
        w_pend_nxt   = bus.cfg_div;
        w_pend_v_nxt = 1'b1;
      end
    end

    w_pos_nxt = (w_state_nxt != OFF) && (w_cnt_nxt < (w_div_nxt >> 1));
  end

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      r_neg <= 1'b0;
    end else begin
      r_neg <= r_pos;
    end
  end

  assign bus.cfg_ready = !r_pend_v;
  assign bus.tick      = w_active && (r_cnt == ZERO);
  assign bus.clk_out   = r_div[0] ? (r_pos | r_neg) : r_pos;
  assign bus.div_cur   = r_div;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed and randomized bench for clk_div_ctrl
// Reference tracks period start and length; clk_out is high for the first D half-cycles.
module tb_clk_div_ctrl;

  localparam int W   = 4;
  localparam int DEF = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  clk_div_ctrl_if #(.W(W)) bus ();

  clk_div_ctrl #(.W(W), .DEF_DIV(DEF)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_D      = DEF;
  int m_cyc    = 0;
  int m_pend   = 0;
  bit m_run    = 1'b0;
  bit m_pend_v = 1'b0;
  bit m_err    = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_D      = DEF;
    m_cyc    = 0;
    m_pend   = 0;
    m_run    = 1'b0;
    m_pend_v = 1'b0;
    m_err    = 1'b0;
  endfunction

  function automatic void model_step();
    bit old_run;
    bit xfer;
    int d_in;
    old_run = m_run;
    xfer    = bus.cfg_valid && !m_pend_v;
    d_in    = int'(bus.cfg_div);
    m_err   = 1'b0;
    if (old_run) begin
      if (m_cyc == m_D - 1) begin
        if (m_pend_v) begin
          m_D      = m_pend;
          m_pend_v = 1'b0;
        end
        m_cyc = 0;
        m_run = bus.en;
      end else begin
        m_cyc++;
      end
    end
    if (xfer) begin
      if (d_in < 2) m_err = 1'b1;
      else if (!old_run) m_D = d_in;
      else begin
        m_pend   = d_in;
        m_pend_v = 1'b1;
      end
    end
    if (!old_run && bus.en) begin
      m_run = 1'b1;
      m_cyc = 0;
    end
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else model_step();
  end

  always begin
    @(posedge clk);
    #1;
    chk("tick", 32'(bus.tick), 32'(m_run && (m_cyc == 0)));
    chk("clk_out_first_half", 32'(bus.clk_out), 32'(m_run && (2 * m_cyc < m_D)));
    chk("div_cur", 32'(bus.div_cur), 32'(m_D));
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(!m_pend_v));
    chk("err", 32'(bus.err), 32'(m_err));
    @(negedge clk);
    #1;
    chk("clk_out_second_half", 32'(bus.clk_out), 32'(m_run && (2 * m_cyc + 1 < m_D)));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic record(input int n, output logic [31:0] co, output logic [31:0] tk);
    co = '0;
    tk = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      co = {co[30:0], bus.clk_out};
      tk = {tk[30:0], bus.tick};
      #5;
      co = {co[30:0], bus.clk_out};
    end
  endtask

  task automatic do_reset();
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_clk_out_async", 32'(bus.clk_out), 32'd0);
    chk("rst_div_cur", 32'(bus.div_cur), 32'(DEF));
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    step();
    step();
    rstn = 1'b1;
  endtask

  logic [31:0] co, tk;

  initial begin
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    step();
    step();
    step();
    chk("reset_clk_out", 32'(bus.clk_out), 32'd0);
    chk("reset_tick", 32'(bus.tick), 32'd0);
    chk("reset_err", 32'(bus.err), 32'd0);
    chk("reset_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("reset_div_cur", 32'(bus.div_cur), 32'(DEF));
    rstn = 1'b1;
    step();
    chk("off_idle_clk_out", 32'(bus.clk_out), 32'd0);

    // D=4 from reset: first rise right after en is sampled
    bus.en = 1'b1;
    record(8, co, tk);
    chk("d4_clk_pattern", co, 32'hF0F0);
    chk("d4_tick_pattern", tk, 32'h88);

    // switch to 7 mid-period
    step();
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 4'd7;
    step();
    bus.cfg_valid = 1'b0;
    chk("pend_cfg_ready_low", 32'(bus.cfg_ready), 32'd0);
    chk("pend_div_unchanged", 32'(bus.div_cur), 32'd4);
    record(9, co, tk);
    chk("d4_to_d7_clk", co, 32'(18'b001111111000000011));
    chk("d4_to_d7_tick", tk, 32'(9'b010000001));
    chk("d7_div_cur", 32'(bus.div_cur), 32'd7);
    chk("d7_cfg_ready_back", 32'(bus.cfg_ready), 32'd1);

    // illegal divisor while running
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 4'd1;
    step();
    bus.cfg_valid = 1'b0;
    chk("illegal_err_pulse", 32'(bus.err), 32'd1);
    chk("illegal_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("illegal_div_kept", 32'(bus.div_cur), 32'd7);
    step();
    chk("illegal_err_cleared", 32'(bus.err), 32'd0);

    // D=5 configured in OFF
    bus.en = 1'b0;
    do_reset();
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 4'd5;
    step();
    bus.cfg_valid = 1'b0;
    chk("off_cfg_div_cur", 32'(bus.div_cur), 32'd5);
    chk("off_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    bus.en = 1'b1;
    record(5, co, tk);
    chk("d5_clk_pattern", co, 32'(10'b1111100000));
    chk("d5_tick_pattern", tk, 32'(5'b10000));
    step();
    bus.en = 1'b0;
    record(6, co, tk);
    chk("d5_stop_clk", co, 32'(12'b111000000000));
    chk("d5_stop_tick", tk, 32'd0);

    // D=6: stop at cnt=1, then resume mid-stop at cnt=3
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 4'd6;
    step();
    bus.cfg_valid = 1'b0;
    chk("d6_div_cur", 32'(bus.div_cur), 32'd6);
    bus.en = 1'b1;
    step();
    step();
    bus.en = 1'b0;
    record(6, co, tk);
    chk("d6_stop_clk", co, 32'(12'b110000000000));
    chk("d6_stop_tick", tk, 32'd0);
    step();
    bus.en = 1'b1;
    step();
    step();
    bus.en = 1'b0;
    step();
    step();
    bus.en = 1'b1;
    record(8, co, tk);
    chk("d6_resume_clk", co, 32'(16'b0000111111000000));
    chk("d6_resume_tick", tk, 32'(8'b00100000));

    // reset while high with a pending update
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 4'd9;
    step();
    bus.cfg_valid = 1'b0;
    chk("pre_rst_ready_low", 32'(bus.cfg_ready), 32'd0);
    chk("pre_rst_clk_high", 32'(bus.clk_out), 32'd1);
    do_reset();
    record(8, co, tk);
    chk("post_rst_clk", co, 32'hF0F0);
    chk("post_rst_tick", tk, 32'h88);
    chk("post_rst_div_cur", 32'(bus.div_cur), 32'(DEF));

    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 9) == 0) bus.en = !bus.en;
      bus.cfg_valid = ($urandom_range(0, 5) == 0);
      bus.cfg_div   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
